// File: rtl/ezusb_lsi_master.sv
// Host-side driver for the low-speed interface: serialises one 32-bit write or read
// per request onto data_clk/mosi/stop and samples the receiver's miso reply.
module ezusb_lsi_master #(
  parameter int BIT_CYCLES = 8,
  parameter int READ_WAIT  = 16
) (
  input  logic        clk,
  input  logic        reset_in,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [7:0]  req_addr,
  input  logic [31:0] req_wdata,
  output logic        done,
  output logic [31:0] rd_data,
  output logic        data_clk,
  output logic        mosi,
  output logic        stop,
  input  logic        miso
);
  localparam int CW  = $clog2(BIT_CYCLES);
  localparam int RWW = $clog2(READ_WAIT + 1);
  // Counter values one cycle ahead: registered outputs land on the cycle after the match.
  localparam logic [CW-1:0]  C_EDGE  = CW'(BIT_CYCLES / 2 - 1);
  localparam logic [CW-1:0]  C_DONE  = CW'(BIT_CYCLES - 2);
  localparam logic [CW-1:0]  C_LAST  = CW'(BIT_CYCLES - 1);
  localparam logic [RWW-1:0] RW_LAST = RWW'(READ_WAIT - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SHIFT  = 3'd1;
  localparam logic [2:0] S_COMMIT = 3'd2;
  localparam logic [2:0] S_RWAIT  = 3'd3;
  localparam logic [2:0] S_READ   = 3'd4;
  localparam logic [2:0] S_GAP    = 3'd5;

  logic [2:0]     state;
  logic [CW-1:0]  cnt;
  logic [RWW-1:0] rw_cnt;
  logic [5:0]     bit_idx;
  logic           wr;
  logic [39:0]    sh;
  logic [31:0]    rd_shift;
  logic           miso_m, miso_s;
  logic [39:0]    frame;
  logic           slot_end, edge_cyc;

  // Writes send data then address; reads send only the address.
  assign frame    = req_write ? {req_addr, req_wdata} : {32'd0, req_addr};
  assign slot_end = (cnt == C_LAST);
  assign edge_cyc = (cnt == C_EDGE);

  always_ff @(posedge clk or posedge reset_in) begin
    if (reset_in) begin
      miso_m <= 1'b0;
      miso_s <= 1'b0;
    end else begin
      miso_m <= miso;
      miso_s <= miso_m;
    end
  end

  always_ff @(posedge clk or posedge reset_in) begin
    if (reset_in) begin
      state     <= S_IDLE;
      cnt       <= '0;
      rw_cnt    <= '0;
      bit_idx   <= '0;
      wr        <= 1'b0;
      sh        <= '0;
      rd_shift  <= '0;
      req_ready <= 1'b0;
      done      <= 1'b0;
      rd_data   <= '0;
      data_clk  <= 1'b0;
      mosi      <= 1'b0;
      stop      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == S_SHIFT || state == S_COMMIT || state == S_READ || state == S_GAP)
        cnt <= slot_end ? '0 : cnt + CW'(1);
      case (state)
        S_IDLE: begin
          stop      <= 1'b0;
          mosi      <= 1'b0;
          req_ready <= !(req_valid && req_ready);
          if (req_valid && req_ready) begin
            wr      <= req_write;
            sh      <= {1'b0, frame[39:1]};
            mosi    <= frame[0];
            bit_idx <= '0;
            cnt     <= '0;
            state   <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (edge_cyc) data_clk <= ~data_clk;
          if (slot_end) begin
            if (bit_idx == (wr ? 6'd39 : 6'd7)) begin
              stop  <= 1'b1;
              mosi  <= ~wr;
              state <= S_COMMIT;
            end else begin
              mosi    <= sh[0];
              sh      <= {1'b0, sh[39:1]};
              bit_idx <= bit_idx + 6'd1;
            end
          end
        end
        S_COMMIT: begin
          if (edge_cyc) data_clk <= ~data_clk;
          if (slot_end) begin
            if (wr) begin
              stop  <= 1'b0;
              mosi  <= 1'b0;
              state <= S_GAP;
            end else begin
              rw_cnt <= '0;
              state  <= S_RWAIT;
            end
          end
        end
        S_RWAIT: begin
          rw_cnt <= rw_cnt + RWW'(1);
          if (rw_cnt == RW_LAST) begin
            mosi    <= 1'b0;
            bit_idx <= '0;
            state   <= S_READ;
          end
        end
        S_READ: begin
          // Sample just before our own edge: a full slot after the previous edge.
          if (edge_cyc) begin
            rd_shift[bit_idx[4:0]] <= miso_s;
            if (bit_idx != 6'd31) data_clk <= ~data_clk;
          end
          if (slot_end) begin
            if (bit_idx == 6'd31) begin
              stop  <= 1'b0;
              state <= S_GAP;
            end else begin
              bit_idx <= bit_idx + 6'd1;
            end
          end
        end
        S_GAP: begin
          if (cnt == C_DONE) begin
            done <= 1'b1;
            if (!wr) rd_data <= rd_shift;
          end
          if (slot_end) begin
            req_ready <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
